// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the line memory responder.
package mem_resp_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_W    = 5;
  localparam int DEF_IDX_W   = 9;
  localparam int DEF_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_ram.sv
// Line storage: synchronous write port plus a registered, read-enabled read port
// whose output register resets to zero and holds between reads.
module line_ram #(
  parameter int LINE_W = 256,
  parameter int IDX_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**IDX_W];

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)   rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency off-chip line memory answering one cache request at a time.
// Optional protocol checker enabled by defining MEM_PROTOCOL_CHECK_EN.
module line_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              err_o
);

  state_t            state;
  logic [7:0]        cnt;
  logic              req_write;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;

  logic [IDX_W-1:0]  in_idx;
  logic              commit;
  logic              commit_write;
  logic [IDX_W-1:0]  ram_idx;
  logic [LINE_W-1:0] ram_wdata;
  logic              unused_addr;

  assign in_idx      = mem_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
  assign unused_addr = ^{mem_addr_i[31:IDX_W+OFFSET_W], mem_addr_i[OFFSET_W-1:0]};

  // With LATENCY=1 the commit happens on the accepting edge, so the RAM must
  // see the live inputs in IDLE rather than the not-yet-captured registers.
  assign commit       = ((state == IDLE) && mem_enable_i && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 8'd0));
  assign commit_write = (state == IDLE) ? mem_write_i : req_write;
  assign ram_idx      = (state == IDLE) ? in_idx : req_idx;
  assign ram_wdata    = (state == IDLE) ? mem_data_i : req_data;

  line_ram #(
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .idx    (ram_idx),
    .we     (commit && commit_write && !rst_i),
    .wdata  (ram_wdata),
    .re     (commit && !commit_write && !rst_i),
    .rdata  (mem_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mem_ack_o <= 1'b0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack_o <= 1'b0;
          if (mem_enable_i) begin
            req_write <= mem_write_i;
            req_idx   <= in_idx;
            req_data  <= mem_data_i;
            cnt       <= 8'(LATENCY - 1);
            if (LATENCY == 1) begin
              state     <= ACK;
              mem_ack_o <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state     <= ACK;
            mem_ack_o <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_PROTOCOL_CHECK_EN
  logic violation;

  assign violation = !mem_enable_i ||
                     (mem_write_i != req_write) ||
                     (in_idx != req_idx) ||
                     (req_write && (mem_data_i != req_data));

  // Sticky flag; the transaction itself keeps using the captured request.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               err_o <= 1'b0;
    else if ((state == WAIT) && violation)   err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
